// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for pipe_ctrl: stage-stall masks, exception codes,
// FSM state encoding and the redirect-vector helper.
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic [31:0] EXC_INT   = 32'h1;
  localparam logic [31:0] EXC_SYS   = 32'h8;
  localparam logic [31:0] EXC_BREAK = 32'h9;
  localparam logic [31:0] EXC_RI    = 32'ha;
  localparam logic [31:0] EXC_OV    = 32'hc;
  localparam logic [31:0] EXC_TRAP  = 32'hd;
  localparam logic [31:0] EXC_ERET  = 32'he;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HOLD      = 2'd1,
    ST_FLUSH_REC = 2'd2
  } pc_state_e;

  // Unknown nonzero codes fall into the general exception vector.
  function automatic logic [31:0] exc_target(
    input logic [31:0] code,
    input logic [31:0] base,
    input logic [31:0] int_off,
    input logic [31:0] exc_off,
    input logic [31:0] epc
  );
    logic [31:0] t;
    case (code)
      EXC_INT:  t = base + int_off;
      EXC_ERET: t = epc;
      EXC_SYS, EXC_BREAK, EXC_RI, EXC_OV, EXC_TRAP: t = base + exc_off;
      default:  t = base + exc_off;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Stall watchdog: saturating cycle counter with clear/enable and a sticky
// timeout flag that sets the edge after the count reaches TIMEOUT.
module pipe_ctrl_watchdog #(
  parameter int              WD_WIDTH = 16,
  parameter logic [WD_WIDTH-1:0] TIMEOUT = 16'd1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  logic [WD_WIDTH-1:0] r_cnt;
  logic                r_timeout;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != {WD_WIDTH{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_timeout <= 1'b0;
    else if (r_cnt == TIMEOUT)
      r_timeout <= 1'b1;
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// MIPS32 pipeline sequencing controller: stall vector, flush, redirect PC.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BASE      = 32'h0000_0000,
  parameter logic [31:0] INT_OFFSET    = 32'h20,
  parameter logic [31:0] EXC_OFFSET    = 32'h40,
  parameter int          WD_WIDTH      = 16,
  parameter logic [WD_WIDTH-1:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout_o,
  output logic [31:0] perf_stall_cycles_o,
  output logic [31:0] perf_flush_cnt_o
);

  pc_state_e   r_state, w_next;
  logic [5:0]  w_stall;
  logic        w_flush;
  logic [31:0] w_new_pc;
  logic        w_wd_timeout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_next;
  end

  // FLUSH_REC masks every request: they belong to the squashed instructions.
  always_comb begin
    w_next   = ST_RUN;
    w_stall  = STALL_NONE;
    w_flush  = 1'b0;
    w_new_pc = 32'h0;
    if (!rst && r_state != ST_FLUSH_REC) begin
      if (excepttype_i != 32'h0) begin
        w_flush  = 1'b1;
        w_new_pc = exc_target(excepttype_i, VEC_BASE, INT_OFFSET, EXC_OFFSET, cp0_epc_i);
        w_next   = ST_FLUSH_REC;
      end else if (stallreq_from_ex) begin
        w_stall = STALL_EX;
        w_next  = ST_HOLD;
      end else if (stallreq_from_id) begin
        w_stall = STALL_ID;
        w_next  = ST_HOLD;
      end
    end
  end

  assign stall  = w_stall;
  assign flush  = w_flush;
  assign new_pc = w_new_pc;

  pipe_ctrl_watchdog #(
    .WD_WIDTH (WD_WIDTH),
    .TIMEOUT  (STALL_TIMEOUT)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_stall == STALL_NONE),
    .i_en      (w_stall != STALL_NONE),
    .o_timeout (w_wd_timeout)
  );

  assign stall_timeout_o = rst ? 1'b0 : w_wd_timeout;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] r_perf_stall, r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= 32'h0;
      r_perf_flush <= 32'h0;
    end else begin
      if (w_stall != STALL_NONE) r_perf_stall <= r_perf_stall + 32'h1;
      if (w_flush)               r_perf_flush <= r_perf_flush + 32'h1;
    end
  end

  assign perf_stall_cycles_o = rst ? 32'h0 : r_perf_stall;
  assign perf_flush_cnt_o    = rst ? 32'h0 : r_perf_flush;
`else
  assign perf_stall_cycles_o = 32'h0;
  assign perf_flush_cnt_o    = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, stall priority, eret/vector redirect,
// FLUSH_REC masking, watchdog stickiness and perf counters.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_id, stallreq_from_ex;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout_o;
  logic [31:0] perf_stall_cycles_o, perf_flush_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_ctrl #(
    .VEC_BASE      (32'hBFC0_0000),
    .INT_OFFSET    (32'h20),
    .EXC_OFFSET    (32'h40),
    .WD_WIDTH      (16),
    .STALL_TIMEOUT (16'd8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stallreq_from_id    (stallreq_from_id),
    .stallreq_from_ex    (stallreq_from_ex),
    .excepttype_i        (excepttype_i),
    .cp0_epc_i           (cp0_epc_i),
    .stall               (stall),
    .flush               (flush),
    .new_pc              (new_pc),
    .stall_timeout_o     (stall_timeout_o),
    .perf_stall_cycles_o (perf_stall_cycles_o),
    .perf_flush_cnt_o    (perf_flush_cnt_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change 1ns after the edge, checks 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic ex, input logic [31:0] exc);
    stallreq_from_id = id;
    stallreq_from_ex = ex;
    excepttype_i     = exc;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cp0_epc_i = 32'h0;
    drive(1'b0, 1'b1, 32'h8);
    n_chk++;
    if (stall !== 6'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_comb: stall=%b flush=%b new_pc=%h want 0/0/0", stall, flush, new_pc);
    end
    n_chk++;
    if (stall_timeout_o !== 1'b0 || perf_stall_cycles_o !== 32'h0 || perf_flush_cnt_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: to=%b ps=%0d pf=%0d want 0", stall_timeout_o, perf_stall_cycles_o, perf_flush_cnt_o);
    end
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (stall !== 6'b0 || flush !== 1'b0 || stall_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: stall=%b flush=%b to=%b want 0", stall, flush, stall_timeout_o);
    end
    // In RUN a request must be honoured immediately.
    drive(1'b0, 1'b1, 32'h0);
    n_chk++;
    if (stall !== 6'b001111) begin
      n_fail++;
      $display("FAIL post_reset_run: stall=%b want 001111", stall);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_stall_seq();
    logic [5:0] exp_s [5];
    logic       ids [5];
    logic       exs [5];
    exp_s = '{6'b000111, 6'b001111, 6'b001111, 6'b001111, 6'b000000};
    ids   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exs   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(ids[i], exs[i], 32'h0);
      n_chk++;
      if (stall !== exp_s[i] || flush !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_seq[%0d]: stall=%b flush=%b want %b/0", i, stall, flush, exp_s[i]);
      end
      tick();
    end
  endtask

  task automatic test_eret();
    cp0_epc_i = 32'h0000_1234;
    drive(1'b0, 1'b1, 32'he);
    n_chk++;
    if (flush !== 1'b1 || new_pc !== 32'h1234 || stall !== 6'b0) begin
      n_fail++;
      $display("FAIL eret: flush=%b new_pc=%h stall=%b want 1/00001234/000000", flush, new_pc, stall);
    end
    tick();
    n_chk++;
    if (flush !== 1'b0 || stall !== 6'b0 || new_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_rec_mask: flush=%b stall=%b new_pc=%h want 0/000000/0", flush, stall, new_pc);
    end
    tick();
    drive(1'b0, 1'b1, 32'h0);
    n_chk++;
    if (stall !== 6'b001111 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL after_rec_run: stall=%b flush=%b want 001111/0", stall, flush);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_vectors();
    logic [31:0] codes [4];
    logic [31:0] exp_pc [4];
    codes  = '{32'h1, 32'hc, 32'h3, 32'h9};
    exp_pc = '{32'hBFC0_0020, 32'hBFC0_0040, 32'hBFC0_0040, 32'hBFC0_0040};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, codes[i]);
      n_chk++;
      if (flush !== 1'b1 || new_pc !== exp_pc[i] || stall !== 6'b0) begin
        n_fail++;
        $display("FAIL vector[%0d]: flush=%b new_pc=%h stall=%b want 1/%h/000000", i, flush, new_pc, stall, exp_pc[i]);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, 32'h8);
    tick();
    drive(1'b0, 1'b0, 32'h1);
    n_chk++;
    if (flush !== 1'b0 || new_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL back_to_back: flush=%b new_pc=%h want 0/0", flush, new_pc);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    drive(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    n_chk++;
    if (stall_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_early: stall_timeout_o=%b want 0", stall_timeout_o);
    end
    for (int i = 0; i < 3; i++) tick();
    n_chk++;
    if (stall_timeout_o !== 1'b1 || stall !== 6'b001111) begin
      n_fail++;
      $display("FAIL wd_fire: to=%b stall=%b want 1/001111", stall_timeout_o, stall);
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    n_chk++;
    if (stall_timeout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_sticky: stall_timeout_o=%b want 1", stall_timeout_o);
    end
    do_reset();
    n_chk++;
    if (stall_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_clear: stall_timeout_o=%b want 0", stall_timeout_o);
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_s, exp_f;
`ifdef PIPE_CTRL_PERF_CNT_EN
    exp_s = 32'd5;
    exp_f = 32'd2;
`else
    exp_s = 32'd0;
    exp_f = 32'd0;
`endif
    do_reset();
    drive(1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    drive(1'b0, 1'b0, 32'h8);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h9);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
    n_chk++;
    if (perf_stall_cycles_o !== exp_s || perf_flush_cnt_o !== exp_f) begin
      n_fail++;
      $display("FAIL perf: stall_cycles=%0d flush_cnt=%0d want %0d/%0d",
               perf_stall_cycles_o, perf_flush_cnt_o, exp_s, exp_f);
    end
  endtask

  initial begin
    rst = 1'b1;
    stallreq_from_id = 1'b0;
    stallreq_from_ex = 1'b0;
    excepttype_i = 32'h0;
    cp0_epc_i = 32'h0;
    #2;
    test_reset();
    test_stall_seq();
    test_eret();
    test_vectors();
    test_back_to_back();
    test_watchdog();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
